// File: rtl/udp_rx_header_parser_if.sv
// Signal bundle between an IP payload stream source and the UDP RX header parser.
// The slave modport is the parser's view; the master modport is the upstream/downstream view.
interface udp_rx_header_parser_if #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = DATA_W / 8
);
  logic              data_v_i;
  logic              start_i;
  logic [DATA_W-1:0] data_i;
  logic [KEEP_W-1:0] keep_i;
  logic              last_i;

  logic              hdr_v_o;
  logic [15:0]       src_port_o;
  logic [15:0]       dst_port_o;
  logic [15:0]       len_o;
  logic              checksum_v_o;
  logic [15:0]       checksum_o;
  logic              data_v_o;
  logic [DATA_W-1:0] data_o;
  logic [KEEP_W-1:0] keep_o;
  logic              last_o;
  logic              err_len_v_o;

  modport slave (
    input  data_v_i, start_i, data_i, keep_i, last_i,
    output hdr_v_o, src_port_o, dst_port_o, len_o, checksum_v_o, checksum_o,
           data_v_o, data_o, keep_o, last_o, err_len_v_o
  );

  modport master (
    output data_v_i, start_i, data_i, keep_i, last_i,
    input  hdr_v_o, src_port_o, dst_port_o, len_o, checksum_v_o, checksum_o,
           data_v_o, data_o, keep_o, last_o, err_len_v_o
  );
endinterface

// File: rtl/udp_rx_header_parser.sv
// UDP RX header parser: strips the 8-byte UDP header, reports its fields and forwards
// the payload trimmed to the length field, flagging truncated or aborted datagrams.
module udp_rx_header_parser #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = DATA_W / 8
) (
  input  logic                    clk,
  input  logic                    reset,
  udp_rx_header_parser_if.slave   bus
);

  localparam int CNT_W = $clog2(KEEP_W + 1);

  typedef enum logic [1:0] {IDLE, HDR1, PAYLOAD, DISCARD} state_t;

  state_t            state_reg, state_next;
  logic [15:0]       remaining_reg, remaining_next;
  logic [15:0]       src_reg, src_next;
  logic [15:0]       dst_reg, dst_next;
  logic [15:0]       len_reg, len_next;
  logic [15:0]       csum_reg, csum_next;
  logic              hdr_v_reg, hdr_v_next;
  logic              data_v_reg, data_v_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [KEEP_W-1:0] keep_reg, keep_next;
  logic              last_reg, last_next;
  logic              err_reg, err_next;

  // Header words carry two big-endian 16-bit fields each, byte 0 in the low lane.
  logic [15:0]       word_lo, word_hi;
  logic [CNT_W-1:0]  beat_bytes;
  logic [KEEP_W-1:0] trim_mask;
  logic              fits;

  assign word_lo = {bus.data_i[7:0],   bus.data_i[15:8]};
  assign word_hi = {bus.data_i[23:16], bus.data_i[31:24]};

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      beat_bytes = beat_bytes + CNT_W'(bus.keep_i[i]);
    end
  end

  generate
    for (genvar gi = 0; gi < KEEP_W; gi++) begin : g_trim
      assign trim_mask[gi] = (remaining_reg > 16'(gi));
    end
  endgenerate

  assign fits = (remaining_reg <= 16'(beat_bytes));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      src_reg       <= '0;
      dst_reg       <= '0;
      len_reg       <= '0;
      csum_reg      <= '0;
      hdr_v_reg     <= 1'b0;
      data_v_reg    <= 1'b0;
      data_reg      <= '0;
      keep_reg      <= '0;
      last_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      src_reg       <= src_next;
      dst_reg       <= dst_next;
      len_reg       <= len_next;
      csum_reg      <= csum_next;
      hdr_v_reg     <= hdr_v_next;
      data_v_reg    <= data_v_next;
      data_reg      <= data_next;
      keep_reg      <= keep_next;
      last_reg      <= last_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    src_next       = src_reg;
    dst_next       = dst_reg;
    len_next       = len_reg;
    csum_next      = csum_reg;
    data_next      = data_reg;
    hdr_v_next     = 1'b0;
    data_v_next    = 1'b0;
    keep_next      = '0;
    last_next      = 1'b0;
    err_next       = 1'b0;
    if (bus.data_v_i) begin
      data_next = bus.data_i;
      if (bus.start_i) begin
        src_next = word_lo;
        dst_next = word_hi;
        // A new start while a datagram is still open closes it with an empty last beat.
        if (state_reg == HDR1 || state_reg == PAYLOAD) err_next = 1'b1;
        if (state_reg == PAYLOAD) begin
          data_v_next = 1'b1;
          last_next   = 1'b1;
        end
        if (bus.last_i) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = HDR1;
        end
      end else begin
        case (state_reg)
          HDR1: begin
            len_next       = word_lo;
            csum_next      = word_hi;
            hdr_v_next     = 1'b1;
            remaining_next = word_lo - 16'd8;
            if (word_lo < 16'd8) begin
              err_next   = 1'b1;
              state_next = bus.last_i ? IDLE : DISCARD;
            end else if (word_lo == 16'd8) begin
              data_v_next = 1'b1;
              last_next   = 1'b1;
              state_next  = bus.last_i ? IDLE : DISCARD;
            end else if (bus.last_i) begin
              err_next    = 1'b1;
              data_v_next = 1'b1;
              last_next   = 1'b1;
              state_next  = IDLE;
            end else begin
              state_next = PAYLOAD;
            end
          end
          PAYLOAD: begin
            data_v_next = 1'b1;
            if (fits) begin
              // Bytes past the length field are link padding, not an error.
              keep_next  = bus.keep_i & trim_mask;
              last_next  = 1'b1;
              state_next = bus.last_i ? IDLE : DISCARD;
            end else begin
              keep_next      = bus.keep_i;
              remaining_next = remaining_reg - 16'(beat_bytes);
              if (bus.last_i) begin
                last_next  = 1'b1;
                err_next   = 1'b1;
                state_next = IDLE;
              end
            end
          end
          DISCARD: begin
            if (bus.last_i) state_next = IDLE;
          end
          default: begin
            state_next = state_reg;
          end
        endcase
      end
    end
  end

  assign bus.hdr_v_o      = hdr_v_reg;
  assign bus.checksum_v_o = hdr_v_reg;
  assign bus.src_port_o   = src_reg;
  assign bus.dst_port_o   = dst_reg;
  assign bus.len_o        = len_reg;
  assign bus.checksum_o   = csum_reg;
  assign bus.data_v_o     = data_v_reg;
  assign bus.data_o       = data_reg;
  assign bus.keep_o       = keep_reg;
  assign bus.last_o       = last_reg;
  assign bus.err_len_v_o  = err_reg;

endmodule

// File: tb/tb_udp_rx_header_parser.sv
// Randomized bench for udp_rx_header_parser: datagrams are described at byte level and
// the expected output of every input beat is derived from the length/framing rules.
module tb_udp_rx_header_parser;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  udp_rx_header_parser_if bus ();

  udp_rx_header_parser dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          rst;
    bit          v;
    bit          start;
    bit          last;
    logic [31:0] data;
    logic [3:0]  keep;
    bit          e_v;
    bit          e_last;
    bit          e_err;
    bit          e_hdr;
    logic [3:0]  e_keep;
    logic [31:0] e_data;
    logic [15:0] e_src;
    logic [15:0] e_dst;
    logic [15:0] e_len;
    logic [15:0] e_csum;
  } beat_t;

  beat_t beats[$];
  int    open_kind = 0;   // 0: nothing open, 1: header word 1 pending, 2: payload pending
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  task automatic add_reset();
    beat_t b;
    b = '{default: 0};
    b.rst = 1'b1;
    beats.push_back(b);
    open_kind = 0;
  endtask

  task automatic add_garbage(input int n);
    beat_t b;
    int    nbytes;
    for (int i = 0; i < n; i++) begin
      b = '{default: 0};
      b.v    = 1'b1;
      b.data = $urandom;
      nbytes = $urandom_range(1, 4);
      b.keep = 4'((1 << nbytes) - 1);
      b.last = 1'($urandom_range(0, 1));
      beats.push_back(b);
    end
  endtask

  task automatic add_dgram(input logic [15:0] src, input logic [15:0] dst,
                           input logic [15:0] len, input logic [15:0] csum,
                           input int pay, input int cut, input bit trunc);
    beat_t raw[$];
    beat_t b;
    int    l_pay;
    int    consumed;
    int    nb;
    int    nbytes;
    bit    done;
    b = '{default: 0};
    b.v     = 1'b1;
    b.start = 1'b1;
    b.keep  = 4'hF;
    b.data  = {dst[7:0], dst[15:8], src[7:0], src[15:8]};
    b.e_err = (open_kind != 0);
    if (open_kind == 2) begin
      b.e_v    = 1'b1;
      b.e_last = 1'b1;
      b.e_data = b.data;
    end
    if (trunc) begin
      b.last  = 1'b1;
      b.e_err = 1'b1;
      beats.push_back(b);
      open_kind = 0;
      return;
    end
    raw.push_back(b);

    b = '{default: 0};
    b.v      = 1'b1;
    b.keep   = 4'hF;
    b.last   = (pay == 0);
    b.data   = {csum[7:0], csum[15:8], len[7:0], len[15:8]};
    b.e_hdr  = 1'b1;
    b.e_src  = src;
    b.e_dst  = dst;
    b.e_len  = len;
    b.e_csum = csum;
    b.e_data = b.data;
    done = (len <= 16'd8);
    if (len < 16'd8) begin
      b.e_err = 1'b1;
    end else if (len == 16'd8) begin
      b.e_v    = 1'b1;
      b.e_last = 1'b1;
    end else if (pay == 0) begin
      b.e_v    = 1'b1;
      b.e_last = 1'b1;
      b.e_err  = 1'b1;
      done     = 1'b1;
    end
    raw.push_back(b);

    l_pay    = int'(len) - 8;
    consumed = 0;
    nb       = (pay + 3) / 4;
    for (int i = 0; i < nb; i++) begin
      nbytes = (pay - 4 * i > 4) ? 4 : pay - 4 * i;
      b = '{default: 0};
      b.v    = 1'b1;
      b.data = $urandom;
      b.keep = 4'((1 << nbytes) - 1);
      b.last = (i == nb - 1);
      if (!done) begin
        b.e_v    = 1'b1;
        b.e_data = b.data;
        if (l_pay - consumed <= nbytes) begin
          b.e_keep = 4'((1 << (l_pay - consumed)) - 1);
          b.e_last = 1'b1;
          done     = 1'b1;
        end else begin
          b.e_keep = b.keep;
          consumed += nbytes;
          if (b.last) begin
            b.e_last = 1'b1;
            b.e_err  = 1'b1;
          end
        end
      end
      raw.push_back(b);
    end

    open_kind = 0;
    if (cut > 0 && cut < raw.size()) begin
      open_kind = (cut == 1) ? 1 : ((len > 16'd8) ? 2 : 0);
      for (int i = 1; i < cut; i++) begin
        if (raw[i].e_last) open_kind = 0;
      end
      for (int i = 0; i < cut; i++) beats.push_back(raw[i]);
    end else begin
      foreach (raw[i]) beats.push_back(raw[i]);
    end
  endtask

  task automatic drive(input beat_t b);
    bus.data_v_i = b.v;
    if (b.v) begin
      bus.start_i = b.start;
      bus.last_i  = b.last;
      bus.data_i  = b.data;
      bus.keep_i  = b.keep;
    end else begin
      bus.start_i = 1'($urandom_range(0, 1));
      bus.last_i  = 1'($urandom_range(0, 1));
      bus.data_i  = $urandom;
      bus.keep_i  = 4'hF;
    end
  endtask

  task automatic check_out(input beat_t b);
    chk("data_v", 32'(bus.data_v_o), 32'(b.e_v));
    chk("err_len_v", 32'(bus.err_len_v_o), 32'(b.e_err));
    chk("hdr_v", 32'(bus.hdr_v_o), 32'(b.e_hdr));
    chk("checksum_v", 32'(bus.checksum_v_o), 32'(b.e_hdr));
    if (b.e_v) begin
      chk("keep", 32'(bus.keep_o), 32'(b.e_keep));
      chk("last", 32'(bus.last_o), 32'(b.e_last));
      chk("data", bus.data_o, b.e_data);
    end
    if (b.e_hdr) begin
      chk("src_port", 32'(bus.src_port_o), 32'(b.e_src));
      chk("dst_port", 32'(bus.dst_port_o), 32'(b.e_dst));
      chk("len", 32'(bus.len_o), 32'(b.e_len));
      chk("checksum", 32'(bus.checksum_o), 32'(b.e_csum));
      $display("hdr src %h dst %h len %0d csum %h", bus.src_port_o, bus.dst_port_o,
               bus.len_o, bus.checksum_o);
    end
  endtask

  task automatic run_beats();
    beat_t idle_b;
    beat_t b;
    idle_b = '{default: 0};
    while (beats.size() > 0) begin
      b = beats.pop_front();
      if (b.rst) begin
        reset = 1'b1;
        drive(idle_b);
        for (int i = 0; i < 2; i++) begin
          @(posedge clk);
          #1;
          check_out(idle_b);
        end
        chk("rst_src", 32'(bus.src_port_o), 32'd0);
        chk("rst_len", 32'(bus.len_o), 32'd0);
        chk("rst_data", bus.data_o, 32'd0);
        reset = 1'b0;
        $display("reset applied");
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          drive(idle_b);
          @(posedge clk);
          #1;
          check_out(idle_b);
        end
        drive(b);
        @(posedge clk);
        #1;
        check_out(b);
      end
    end
    drive(idle_b);
  endtask

  initial begin
    int len;
    int pay;
    int cut;
    reset        = 1'b1;
    bus.data_v_i = 1'b0;
    bus.start_i  = 1'b0;
    bus.last_i   = 1'b0;
    bus.data_i   = '0;
    bus.keep_i   = '0;

    add_reset();
    add_dgram(16'h04D2, 16'h1234, 16'd12, 16'hCDAB, 4, 0, 1'b0);
    add_dgram(16'h1111, 16'h2222, 16'd13, 16'h0001, 12, 0, 1'b0);
    add_dgram(16'h3333, 16'h4444, 16'd20, 16'h0002, 4, 0, 1'b0);
    add_dgram(16'h5555, 16'h6666, 16'd8, 16'h0003, 0, 0, 1'b0);
    add_dgram(16'h7777, 16'h8888, 16'd40, 16'h0004, 20, 3, 1'b0);
    add_dgram(16'h9999, 16'hAAAA, 16'd12, 16'h0005, 4, 0, 1'b0);
    add_dgram(16'hBBBB, 16'hCCCC, 16'd30, 16'h0006, 20, 4, 1'b0);
    add_reset();
    add_garbage(3);
    add_dgram(16'hDDDD, 16'hEEEE, 16'd16, 16'h0007, 8, 0, 1'b0);
    add_dgram(16'h0102, 16'h0304, 16'd0, 16'h0000, 0, 0, 1'b1);
    add_dgram(16'h0506, 16'h0708, 16'd5, 16'h0008, 3, 0, 1'b0);
    add_dgram(16'h0A0B, 16'h0C0D, 16'd28, 16'h0009, 12, 1, 1'b0);
    add_dgram(16'h0E0F, 16'h1011, 16'd10, 16'h000A, 7, 0, 1'b0);
    run_beats();

    for (int n = 0; n < 300; n++) begin
      len = ($urandom_range(0, 9) < 2) ? $urandom_range(0, 9) : $urandom_range(9, 48);
      if (len > 8) begin
        pay = len - 8 + $urandom_range(0, 12) - 6;
        if (pay < 0) pay = 0;
      end else begin
        pay = $urandom_range(0, 8);
      end
      cut = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : 0;
      add_dgram(16'($urandom), 16'($urandom), 16'(len), 16'($urandom), pay, cut,
                ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 24) == 0) add_reset();
      if (open_kind == 0 && $urandom_range(0, 4) == 0) add_garbage($urandom_range(1, 3));
      run_beats();
    end

    repeat (3) begin
      @(posedge clk);
      #1;
      chk("tail_data_v", 32'(bus.data_v_o), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
